ifid_queue: RTL and testbench

//  Parametrised IF/ID decoupling queue; next generation of the single-entry IF/ID register.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/ifid_queue_ram.sv | 26 ++
 rtl/ifid_queue.sv | 99 +++++++++
 tb/tb_ifid_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Types and constants shared by fetch, the IF/ID queue and decode.
package pipe_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int ADDR_W_DEF  = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  addr;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_queue_ram.sv
// Entry storage: DEPTH x W flops, one synchronous write port, one asynchronous read port.
// Deliberately not reset; validity is tracked by the queue pointers.
module ifid_queue_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_dat
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: first-word-fall-through FIFO of {instr, addr} with branch flush
// and a saturating I-cache miss counter. Misses are never enqueued.
module ifid_queue
  import pipe_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 4,
  parameter int MISS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_hit,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [MISS_W-1:0]          miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = INSTR_W + ADDR_W;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [MISS_W-1:0] r_miss;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_miss;
  logic [EW-1:0] w_rd_dat;

  // Full/empty come from registered count only, so in_ready never sees out_ready.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & in_hit & ~w_full & ~flush;
  assign w_pop   = ~w_empty & out_ready & ~flush;
  assign w_miss  = in_valid & ~in_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_miss   <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      if (w_miss && (r_miss != '1)) begin
        r_miss <= r_miss + MISS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CW'(DEPTH));
    end
  end

  ifid_queue_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  ({in_instr, in_addr}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_rd_dat)
  );

  // Empty queue presents the NOP encoding so decode sees a bubble.
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_instr = w_empty ? INSTR_W'(NOP_INSTR) : w_rd_dat[ADDR_W +: INSTR_W];
  assign out_addr  = w_empty ? '0 : w_rd_dat[ADDR_W-1:0];
  assign count     = r_count;
  assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_ifid_queue.sv
// Scoreboard bench for ifid_queue; a second instance with a 2-bit miss counter covers saturation.
module tb_ifid_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_hit, flush, out_ready;
  logic [15:0] in_instr, in_addr;
  logic        in_ready, out_valid;
  logic [15:0] out_instr, out_addr;
  logic [2:0]  count;
  logic [7:0]  miss_cnt;
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_instr, s_out_addr;
  logic [2:0]  s_count;
  logic [1:0]  s_miss_cnt;

  always #5 clk = ~clk;

  ifid_queue #(.INSTR_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MISS_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hit(in_hit), .in_instr(in_instr),
    .in_addr(in_addr), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .count(count),
    .miss_cnt(miss_cnt)
  );

  ifid_queue #(.INSTR_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MISS_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hit(in_hit), .in_instr(in_instr),
    .in_addr(in_addr), .in_ready(s_in_ready), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_instr(s_out_instr), .out_addr(s_out_addr), .count(s_count),
    .miss_cnt(s_miss_cnt)
  );

  ifid_entry_t sb[$];
  int mmiss = 0;
  int smiss = 0;
  bit model_ok = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Compare outputs against the model, then advance the model and the clock by one cycle.
  task automatic tick();
    bit          push, pop, miss;
    int          mcount;
    logic [15:0] e_instr, e_addr;
    mcount = sb.size();
    if (model_ok) begin
      e_instr = (mcount != 0) ? sb[0].instr : 16'h0;
      e_addr  = (mcount != 0) ? sb[0].addr  : 16'h0;
      check("in_ready",  64'(in_ready),  64'(mcount < DEPTH));
      check("out_valid", 64'(out_valid), 64'(mcount != 0));
      check("count",     64'(count),     64'(mcount));
      check("out_instr", 64'(out_instr), 64'(e_instr));
      check("out_addr",  64'(out_addr),  64'(e_addr));
      check("miss_cnt",  64'(miss_cnt),  64'(mmiss));
      check("small",
            64'({s_in_ready, s_out_valid, s_count, s_out_instr, s_out_addr, s_miss_cnt}),
            64'({mcount < DEPTH, mcount != 0, 3'(mcount), e_instr, e_addr, 2'(smiss)}));
    end
    push = in_valid && in_hit && (mcount < DEPTH) && !flush;
    pop  = (mcount != 0) && out_ready && !flush;
    miss = in_valid && !in_hit;
    if (rst) begin
      sb.delete();
      mmiss = 0;
      smiss = 0;
      model_ok = 1'b1;
    end else begin
      if (flush) begin
        sb.delete();
      end else begin
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back('{instr: in_instr, addr: in_addr});
      end
      if (miss && mmiss < 255) mmiss++;
      if (miss && smiss < 3)   smiss++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_hit(input logic [15:0] instr, input logic [15:0] addr);
    in_valid = 1'b1;
    in_hit   = 1'b1;
    in_instr = instr;
    in_addr  = addr;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_hit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_addr = '0;
    @(negedge clk);

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_count",     64'(count),     64'd0);
    check("rst_miss",      64'(miss_cnt),  64'd0);

    // Fill to full, fifth push refused, then drain in order
    for (int i = 1; i <= 5; i++) push_hit(16'(16'h1111 * i), 16'(16'h0010 + i));
    check("full_count",    64'(count),    64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head",     64'(out_instr), 64'h1111);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 64'(out_instr), 64'(16'(16'h1111 * i)));
      tick();
    end
    check("drained_valid", 64'(out_valid), 64'd0);
    tick();

    // Streaming with simultaneous push/pop, pointers wrap several times
    in_valid = 1'b1; in_hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_instr = 16'(16'h0100 + i);
      in_addr  = 16'(16'h0200 + i);
      tick();
      check("stream_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_empty", 64'(out_valid), 64'd0);

    // Alternating hit/miss
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_hit   = (i % 2 == 0);
      in_instr = 16'(16'h2000 + i);
      in_addr  = 16'(16'h3000 + i);
      tick();
    end
    check("miss_count", 64'(count),      64'd4);
    check("miss_cnt5",  64'(miss_cnt),   64'd5);
    check("miss_sat",   64'(s_miss_cnt), 64'd3);
    in_hit = 1'b0;
    tick();
    in_valid = 1'b0;
    check("miss_cnt6",  64'(miss_cnt),   64'd6);
    check("miss_sat6",  64'(s_miss_cnt), 64'd3);
    out_ready = 1'b1;
    repeat (5) tick();

    // Flush with three entries, push/pop in the flush cycle are discarded
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_hit(16'(16'h4000 + i), 16'(16'h5000 + i));
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_hit = 1'b1; out_ready = 1'b1;
    in_instr = 16'hDEAD; in_addr = 16'h0D0D;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 64'(count),     64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    push_hit(16'hBEEF, 16'h0B0B);
    check("post_flush_head", 64'(out_instr), 64'hBEEF);
    out_ready = 1'b1;
    tick();

    // Reset mid-operation, then normal traffic
    out_ready = 1'b0;
    push_hit(16'h7777, 16'h0070);
    push_hit(16'h8888, 16'h0080);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 64'(count),     64'd0);
    check("mid_rst_instr", 64'(out_instr), 64'd0);
    check("mid_rst_miss",  64'(miss_cnt),  64'd0);
    push_hit(16'h9999, 16'h0090);
    push_hit(16'hAAAA, 16'h00A0);
    out_ready = 1'b1;
    check("after_rst_head", 64'(out_instr), 64'h9999);
    tick();
    tick();
    tick();

    // Flush and reset together
    out_ready = 1'b0;
    push_hit(16'hCCCC, 16'h00C0);
    in_valid = 1'b1; in_hit = 1'b0;
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rst_flush_count", 64'(count),    64'd0);
    check("rst_flush_miss",  64'(miss_cnt), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
